// File: rtl/pc_sequencer_if.sv
// Fetch/decode/redirect signal bundle for pc_sequencer.
// master = sequencer side, slave = memory/decode/branch environment side.
interface pc_sequencer_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        halt;
  logic        fault;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, fault,
    input  imem_ready, imem_rdata, stall, br_taken, br_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, fault,
    output imem_ready, imem_rdata, stall, br_taken, br_target, halt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Single-outstanding instruction fetch sequencer: BOOT -> FETCH <-> HOLD, with redirect and halt.
// Optional macro PC_ALIGN_CHECK_EN: misaligned branch targets raise a sticky fault and halt.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.master bus
);
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, HALTED} state_t;

  state_t      state_reg;
  logic [63:0] pc_reg;
  logic [63:0] instr_pc_reg;
  logic [31:0] instr_reg;
  logic        instr_valid_reg;
  logic        imem_req_reg;
  logic        misaligned;

  assign bus.imem_req    = imem_req_reg;
  assign bus.imem_addr   = pc_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
  assign bus.instr_valid = instr_valid_reg;

`ifdef PC_ALIGN_CHECK_EN
  logic fault_reg;
  assign misaligned = |bus.br_target[1:0];
  assign bus.fault  = fault_reg;

  always_ff @(posedge clk) begin
    if (reset)
      fault_reg <= 1'b0;
    else if (state_reg != HALTED && bus.br_taken && misaligned)
      fault_reg <= 1'b1;
  end
`else
  assign misaligned = 1'b0;
  assign bus.fault  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      imem_req_reg    <= 1'b0;
      instr_reg       <= 32'h0;
      instr_pc_reg    <= 64'h0;
      instr_valid_reg <= 1'b0;
    end else if (state_reg != HALTED) begin
      // Redirect beats halt; any fetch completing this cycle is dropped.
      if (bus.br_taken) begin
        instr_valid_reg <= 1'b0;
        if (misaligned) begin
          state_reg    <= HALTED;
          imem_req_reg <= 1'b0;
        end else begin
          pc_reg       <= {bus.br_target[63:2], 2'b00};
          state_reg    <= FETCH;
          imem_req_reg <= 1'b1;
        end
      end else if (bus.halt) begin
        state_reg       <= HALTED;
        imem_req_reg    <= 1'b0;
        instr_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          BOOT: begin
            state_reg    <= FETCH;
            imem_req_reg <= 1'b1;
          end
          FETCH: begin
            if (bus.imem_ready) begin
              instr_reg       <= bus.imem_rdata;
              instr_pc_reg    <= pc_reg;
              instr_valid_reg <= 1'b1;
              pc_reg          <= pc_reg + 64'd4;
              state_reg       <= HOLD;
              imem_req_reg    <= 1'b0;
            end
          end
          HOLD: begin
            // Next fetch only starts once decode has taken the held word.
            if (!bus.stall) begin
              instr_valid_reg <= 1'b0;
              state_reg       <= FETCH;
              imem_req_reg    <= 1'b1;
            end
          end
          default: begin
            state_reg <= state_reg;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver predicts fetched words into a queue, monitor pops on delivery.
module tb_pc_sequencer;
  localparam logic [63:0] RST_PC = 64'h100;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] data;
  } fetch_t;

  logic clk = 1'b0;
  logic reset;
  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  fetch_t      exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  logic [63:0] model_pc;
  bit          model_halted;
  bit          exp_fault;
  bit          mon_en = 1'b0;
  logic        last_stall, last_br, last_halt;
  logic        prev_valid;
  logic [31:0] held_instr;
  logic [63:0] held_pc;
  logic [63:0] pool [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    last_stall <= bus.stall;
    last_br    <= bus.br_taken;
    last_halt  <= bus.halt;
  end

  // Monitor: decides from the previous cycle's inputs what the decode-side outputs must do.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && (last_br || last_halt || !last_stall)) begin
        check("consume_clear", 64'(bus.instr_valid), 64'd0);
      end else if (prev_valid) begin
        check("stall_valid", 64'(bus.instr_valid), 64'd1);
        check("stall_instr", 64'(bus.instr), 64'(held_instr));
        check("stall_pc", bus.instr_pc, held_pc);
      end else if (bus.instr_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h, expected no instruction", bus.instr_pc);
        end else begin
          fetch_t e;
          e = exp_q.pop_front();
          check("deliver_pc", bus.instr_pc, e.pc);
          check("deliver_instr", 64'(bus.instr), 64'(e.data));
          delivered++;
          $display("deliver pc=%h instr=%h", bus.instr_pc, bus.instr);
        end
        held_instr = bus.instr;
        held_pc    = bus.instr_pc;
      end
      if (bus.instr_valid) check("one_outstanding", 64'(bus.imem_req), 64'd0);
      prev_valid = bus.instr_valid;
    end
  end

  // mode: 0 random ready/stall, 1 ready=1 stall=0, 2 ready=1 stall=1, 3 ready=0 stall=0
  task automatic step(input bit br, input logic [63:0] tgt, input bit hlt, input int mode);
    bit          rdy;
    logic [31:0] data;
    check("fault", 64'(bus.fault), 64'(exp_fault));
    if (model_halted) begin
      check("halted_req", 64'(bus.imem_req), 64'd0);
      check("halted_valid", 64'(bus.instr_valid), 64'd0);
    end else if (bus.imem_req) begin
      check("fetch_addr", bus.imem_addr, model_pc);
    end
    case (mode)
      0:       rdy = ($urandom_range(0, 2) != 0);
      3:       rdy = 1'b0;
      default: rdy = 1'b1;
    endcase
    data           = $urandom;
    bus.imem_ready = rdy;
    bus.imem_rdata = data;
    bus.br_taken   = br;
    bus.br_target  = tgt;
    bus.halt       = hlt;
    case (mode)
      0:       bus.stall = ($urandom_range(0, 2) == 0);
      2:       bus.stall = 1'b1;
      default: bus.stall = 1'b0;
    endcase
    if (!model_halted) begin
      if (br) begin
`ifdef PC_ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) begin
          model_halted = 1'b1;
          exp_fault    = 1'b1;
        end else
`endif
        model_pc = {tgt[63:2], 2'b00};
      end else if (hlt) begin
        model_halted = 1'b1;
      end else if (bus.imem_req && rdy) begin
        exp_q.push_back(fetch_t'{pc: model_pc, data: data});
        model_pc = model_pc + 64'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en         = 1'b0;
    reset          = 1'b1;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.stall      = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_target  = 64'h0;
    bus.halt       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_fault", 64'(bus.fault), 64'd0);
    check("rst_instr", 64'(bus.instr), 64'd0);
    check("rst_instr_pc", bus.instr_pc, 64'd0);
    check("rst_addr", bus.imem_addr, RST_PC);
    exp_q.delete();
    model_pc     = RST_PC;
    model_halted = 1'b0;
    exp_fault    = 1'b0;
    reset        = 1'b0;
    mon_en       = 1'b1;
    @(negedge clk);
    check("boot_one_cycle", 64'(bus.imem_req), 64'd1);
  endtask

  initial begin
    pool[0] = 64'h0000_0000_0000_2000;
    pool[1] = 64'hFFFF_FFFF_FFFF_FFF8;
    pool[2] = 64'h0000_0000_0000_0100;
    pool[3] = 64'h0000_0000_8000_0040;

    do_reset();
    repeat (12) step(1'b0, 64'h0, 1'b0, 1);
    repeat (3)  step(1'b0, 64'h0, 1'b0, 2);
    repeat (6)  step(1'b0, 64'h0, 1'b0, 1);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] tgt;
      tgt = pool[$urandom_range(0, 3)] + 64'({$urandom_range(0, 15), 2'b00});
`ifndef PC_ALIGN_CHECK_EN
      tgt[1:0] = 2'($urandom_range(0, 3));
`endif
      step($urandom_range(0, 15) == 0, tgt, 1'b0, 0);
    end

    // Wrap through the top of the address space.
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1);
    repeat (8) step(1'b0, 64'h0, 1'b0, 1);
    // Redirect on the same cycle a fetch completes.
    step(1'b1, 64'h2000, 1'b0, 1);
    check("redirect_addr", bus.imem_addr, 64'h2000);
    repeat (4) step(1'b0, 64'h0, 1'b0, 1);
    // Halt together with redirect: redirect wins, then a lone halt parks the sequencer.
    step(1'b1, 64'h3000, 1'b1, 1);
    check("br_over_halt_req", 64'(bus.imem_req), 64'd1);
    check("br_over_halt_addr", bus.imem_addr, 64'h3000);
    repeat (3) step(1'b0, 64'h0, 1'b0, 1);
    step(1'b0, 64'h0, 1'b1, 0);
    for (int i = 0; i < 6; i++)
      step(1'($urandom_range(0, 1)), 64'h4000, 1'($urandom_range(0, 1)), 0);

    do_reset();
    repeat (6) step(1'b0, 64'h0, 1'b0, 1);
    begin
      logic [63:0] pc_before;
      pc_before = model_pc;
      step(1'b1, 64'h2002, 1'b0, 1);
`ifdef PC_ALIGN_CHECK_EN
      check("align_fault", 64'(bus.fault), 64'd1);
      check("align_pc_hold", bus.imem_addr, pc_before);
      check("align_halted_req", 64'(bus.imem_req), 64'd0);
`else
      check("align_addr", bus.imem_addr, 64'h2000);
      check("align_no_fault", 64'(bus.fault), 64'd0);
      check("align_req", 64'(bus.imem_req | (pc_before == 64'h2000)), 64'd1);
`endif
    end
    repeat (4) step(1'b0, 64'h0, 1'b0, 1);
    repeat (4) step(1'b0, 64'h0, 1'b0, 3);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("enough_deliveries", 64'(delivered >= 40), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, 64'h0, address of the first fetch after reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: imem_req  output  1  instruction-memory fetch request.
REQ-005 Port: imem_addr  output  64  fetch address; equals the internal pc register.
REQ-006 Port: imem_ready  input  1  memory returns imem_rdata this cycle; meaningful only while imem_req=1.
REQ-007 Port: imem_rdata  input  32  fetched instruction word.
REQ-008 Port: instr  output  32  registered instruction presented to decode.
REQ-009 Port: instr_pc  output  64  address that instr was fetched from.
REQ-010 Port: instr_valid  output  1  instr/instr_pc are valid.
REQ-011 Port: stall  input  1  decode cannot accept instr this cycle.
REQ-012 Port: br_taken  input  1  redirect request this cycle.
REQ-013 Port: br_target  input  64  redirect address.
REQ-014 Port: halt  input  1  stop fetching.
REQ-015 Port: fault  output  1  sticky misaligned-branch fault.

Function
REQ-016 The FSM SHALL have four states: BOOT, FETCH, HOLD and HALTED.
REQ-017 BOOT SHALL last exactly one cycle with imem_req=0, then go to FETCH.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; the FSM SHALL wait in FETCH while imem_ready=0.
REQ-019 In FETCH with imem_ready=1, on the next edge: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, state<=HOLD.
REQ-020 In HOLD, imem_req SHALL be 0; decode consumes the instruction in a cycle with instr_valid=1 and stall=0.
REQ-021 On that consume edge, instr_valid SHALL go to 0 and the state to FETCH.
REQ-022 While stall=1, HOLD SHALL keep instr, instr_pc and instr_valid unchanged.
REQ-023 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC+4 = 0).
REQ-024 Event priority SHALL be reset > br_taken > halt > normal sequencing.
REQ-025 br_taken=1 in BOOT, FETCH or HOLD SHALL, on the next edge, set pc<=br_target, clear instr_valid and set state<=FETCH.
REQ-026 A fetch completing (imem_ready=1) in the same cycle as br_taken SHALL be discarded.
REQ-027 br_taken SHALL flush a held instruction regardless of stall.
REQ-028 halt=1 without br_taken SHALL move the FSM to HALTED on the next edge; this applies in every state.
REQ-029 In HALTED: imem_req=0, instr_valid=0, and pc SHALL hold.
REQ-030 HALTED SHALL ignore br_taken, halt and stall, and SHALL be left only by reset.
REQ-031 The sequencer SHALL never issue a new fetch while instr_valid=1, so at most one instruction is outstanding.

Reset
REQ-032 On reset, the next edge SHALL set: state=BOOT, pc=RESET_PC, imem_req=0, instr=0, instr_pc=0, instr_valid=0, fault=0.
REQ-033 Reset SHALL take effect from any state, including mid-fetch or stalled HOLD; an in-flight imem_rdata SHALL be discarded.

Configuration
REQ-034 Macro PC_ALIGN_CHECK_EN defined: br_taken with br_target[1:0]!=0 SHALL leave pc unchanged, set fault<=1 and enter HALTED; fault stays 1 until reset.
REQ-035 PC_ALIGN_CHECK_EN undefined: the sequencer SHALL force br_target[1:0] to 0 when loading pc, and fault SHALL be constant 0 (the port remains present).

Verification
REQ-036 Reset with RESET_PC=64'h100, imem_ready=1 always, stall=0 -> BOOT for 1 cycle, then fetches at 0x100, 0x104, 0x108, one instr_valid pulse per fetch; instr_pc matches each address.
REQ-037 stall=1 for 3 cycles while instr_valid=1 -> instr and instr_pc are held, imem_req=0 throughout, no address is skipped after stall releases.
REQ-038 br_taken=1 with br_target=64'h2000 in the same cycle as imem_ready=1 at 0x10C -> that data is dropped, next imem_addr=0x2000, no instr_valid for 0x10C.
REQ-039 pc=64'hFFFF_FFFF_FFFF_FFFC, fetch completes -> next imem_addr=0.
REQ-040 halt=1 and br_taken=1 together -> redirect wins; a later halt=1 reaches HALTED with imem_req=0; reset then restarts at RESET_PC.
REQ-041 br_target=64'h2002 with PC_ALIGN_CHECK_EN defined -> fault=1, HALTED, pc unchanged; without the macro -> next imem_addr=0x2000, fault=0.
